status_flag_reg: RTL and testbench

Parametrised ALU status register for the 8-bit RISC SPM. It replaces the single zero-flag flip-flop with N flags (default Z, N, C, V in bits 0..3), each with its own write enable. Selected flags can be made sticky. A small LIFO shadow stack saves and restores the flag vector on interrupt or subroutine entry and exit. It sits between the ALU flag outputs and the control unit's branch-condition logic.

---
 rtl/status_flag_reg.sv | 129 ++++++++++++
 tb/tb_status_flag_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/status_flag_reg.sv
// status_flag_reg: ALU status flag register for the 8-bit RISC SPM.
// It holds N per-bit-enabled flags, some of which can be sticky, and a LIFO
// shadow stack that saves and restores the flag vector on entry and exit.
// The stack reports overflow and underflow through two sticky error bits.
module status_flag_reg #(
    parameter int                 N_FLAGS     = 4,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [N_FLAGS-1:0] STICKY_MASK = {N_FLAGS{1'b0}},
    parameter logic [N_FLAGS-1:0] RST_VALUE   = {N_FLAGS{1'b0}},
    localparam int                CNT_W       = $clog2(STACK_DEPTH + 1)
) (
    input  logic               status_flag_clk,
    input  logic               status_flag_rst,
    input  logic [N_FLAGS-1:0] status_flag_in,
    input  logic [N_FLAGS-1:0] status_flag_we,
    input  logic               status_flag_clr_sticky,
    input  logic               status_flag_push,
    input  logic               status_flag_pop,
    input  logic               status_flag_clr_err,
    output logic [N_FLAGS-1:0] status_flag_out,
    output logic [CNT_W-1:0]   status_flag_cnt,
    output logic               status_flag_full,
    output logic               status_flag_empty,
    output logic               status_flag_ovf_err,
    output logic               status_flag_unf_err
);

    // The stack index only needs to address STACK_DEPTH entries.
    // The occupancy counter needs one more code, so that it can also represent "full".
    localparam int              IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STACK_DEPTH);

    logic [N_FLAGS-1:0] flags_q, flags_d;
    logic [N_FLAGS-1:0] upd_s;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_m1_s;
    logic [IDX_W-1:0]   cnt_idx_s, top_idx_s, stk_widx_s;
    logic               stk_we_s;
    logic               full_s, empty_s;
    logic               ovf_q, ovf_d, unf_q, unf_d;
    logic               ovf_ev_s, unf_ev_s;
    logic [N_FLAGS-1:0] stack_q [STACK_DEPTH];

    assign full_s    = (cnt_q == DEPTH_C);
    assign empty_s   = (cnt_q == {CNT_W{1'b0}});
    assign cnt_m1_s  = cnt_q - CNT_W'(1);
    assign cnt_idx_s = cnt_q[IDX_W-1:0];
    assign top_idx_s = cnt_m1_s[IDX_W-1:0];

    // Per-bit flag update: sticky bits only set (or clear via clr_sticky), others load when enabled
    always_comb begin
        upd_s = flags_q;
        for (int i = 0; i < N_FLAGS; i++) begin
            if (STICKY_MASK[i]) begin
                upd_s[i] = (status_flag_clr_sticky ? 1'b0 : flags_q[i])
                           | (status_flag_we[i] & status_flag_in[i]);
            end else if (status_flag_we[i]) begin
                upd_s[i] = status_flag_in[i];
            end else begin
                upd_s[i] = flags_q[i];
            end
        end
    end

    // Stack control: a pop (or a push+pop swap) beats the flag update;
    // a push or pop that cannot be honoured only flags an error and lets the update through
    always_comb begin
        flags_d    = upd_s;
        cnt_d      = cnt_q;
        stk_we_s   = 1'b0;
        stk_widx_s = cnt_idx_s;
        ovf_ev_s   = 1'b0;
        unf_ev_s   = 1'b0;
        if (status_flag_pop) begin
            if (!empty_s) begin
                flags_d = stack_q[top_idx_s];
                if (status_flag_push) begin
                    stk_we_s   = 1'b1;
                    stk_widx_s = top_idx_s;
                end else begin
                    cnt_d = cnt_m1_s;
                end
            end else begin
                unf_ev_s = 1'b1;
            end
        end else if (status_flag_push) begin
            if (!full_s) begin
                stk_we_s   = 1'b1;
                stk_widx_s = cnt_idx_s;
                cnt_d      = cnt_q + CNT_W'(1);
            end else begin
                ovf_ev_s = 1'b1;
            end
        end else begin
            flags_d = upd_s;
        end
        ovf_d = ovf_ev_s | (ovf_q & ~status_flag_clr_err);
        unf_d = unf_ev_s | (unf_q & ~status_flag_clr_err);
    end

    // Live flags, occupancy counter and error bits, with synchronous reset
    always_ff @(posedge status_flag_clk) begin
        if (status_flag_rst) begin
            flags_q <= RST_VALUE;
            cnt_q   <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Shadow stack storage; its contents are don't-care after reset, so it is not cleared
    always_ff @(posedge status_flag_clk) begin
        if (stk_we_s && !status_flag_rst) begin
            stack_q[stk_widx_s] <= flags_q;
        end
    end

    assign status_flag_out     = flags_q;
    assign status_flag_cnt     = cnt_q;
    assign status_flag_full    = full_s;
    assign status_flag_empty   = empty_s;
    assign status_flag_ovf_err = ovf_q;
    assign status_flag_unf_err = unf_q;

endmodule

// File: tb/tb_status_flag_reg.sv
// Testbench for status_flag_reg (N_FLAGS=4, STACK_DEPTH=4, bit 3 sticky).
// A directed vector table is followed by random stimulus checked against a queue-based model.
module tb_status_flag_reg;

    logic       clk = 1'b0;
    logic       rst, cs, push, pop, ce;
    logic [3:0] din, we;
    logic [3:0] dout;
    logic [2:0] cnt;
    logic       full, empty, ovf, unf;

    int checks = 0;
    int errors = 0;

    status_flag_reg #(
        .N_FLAGS(4), .STACK_DEPTH(4), .STICKY_MASK(4'b1000), .RST_VALUE(4'b0000)
    ) dut (
        .status_flag_clk(clk), .status_flag_rst(rst), .status_flag_in(din),
        .status_flag_we(we), .status_flag_clr_sticky(cs), .status_flag_push(push),
        .status_flag_pop(pop), .status_flag_clr_err(ce), .status_flag_out(dout),
        .status_flag_cnt(cnt), .status_flag_full(full), .status_flag_empty(empty),
        .status_flag_ovf_err(ovf), .status_flag_unf_err(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] din;
        logic [3:0] we;
        logic       cs, push, pop, ce;
        logic [3:0] e_out;
        logic [2:0] e_cnt;
        logic       e_ovf, e_unf;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic [3:0] e_out, input logic [2:0] e_cnt,
                           input logic e_ovf, input logic e_unf);
        chk("out",   idx, {4'b0000, dout},  {4'b0000, e_out});
        chk("cnt",   idx, {5'b00000, cnt},  {5'b00000, e_cnt});
        chk("full",  idx, {7'b0000000, full},  {7'b0000000, (e_cnt == 3'd4)});
        chk("empty", idx, {7'b0000000, empty}, {7'b0000000, (e_cnt == 3'd0)});
        chk("ovf",   idx, {7'b0000000, ovf},   {7'b0000000, e_ovf});
        chk("unf",   idx, {7'b0000000, unf},   {7'b0000000, e_unf});
    endtask

    // Behavioural reference model
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_ovf, m_unf;

    task automatic model_step();
        logic [3:0] upd;
        logic       ovf_ev, unf_ev;
        logic [3:0] tmp;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) upd[i] = (cs ? 1'b0 : m_flags[i]) | (we[i] & din[i]);
            else        upd[i] = we[i] ? din[i] : m_flags[i];
        end
        if (rst) begin
            m_flags = 4'b0000;
            m_stack.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (pop && m_stack.size() > 0) begin
                if (push) begin
                    tmp = m_stack[m_stack.size() - 1];
                    m_stack[m_stack.size() - 1] = m_flags;
                    m_flags = tmp;
                end else begin
                    m_flags = m_stack.pop_back();
                end
            end else begin
                if (pop) unf_ev = 1'b1;
                if (push && !pop) begin
                    if (m_stack.size() < 4) m_stack.push_back(m_flags);
                    else ovf_ev = 1'b1;
                end
                m_flags = upd;
            end
            m_ovf = ovf_ev | (m_ovf & ~ce);
            m_unf = unf_ev | (m_unf & ~ce);
        end
    endtask

    initial begin
        //                   rst   in       we       cs    push  pop   ce    out      cnt   ovf   unf
        // Reset and per-bit update
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b0101, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 3'd0, 1'b0, 1'b0});
        // Sticky bit 3
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1000, 3'd0, 1'b0, 1'b0});
        // Stack round-trip
        tbl.push_back('{1'b0, 4'b0011, 4'b1111, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1100, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0001, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b0, 1'b0});
        // Overflow and underflow
        tbl.push_back('{1'b0, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0100, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0110, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 3'd4, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0111, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 3'd3, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 3'd2, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0001, 3'd1, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0011, 3'd0, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 4'b0101, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 3'd0, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0101, 3'd0, 1'b0, 1'b0});
        // Same-cycle push+pop swap, then swap on empty
        tbl.push_back('{1'b0, 4'b0110, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1001, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0110, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0010, 4'b0111, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 3'd0, 1'b0, 1'b0});
        // Reset in mid-sequence discards the stack
        tbl.push_back('{1'b0, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd1, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 3'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1111, 3'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1});
        // Error event together with clr_err keeps the bit set; then clear it
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 3'd0, 1'b0, 1'b0});

        rst = 1'b0; din = 4'b0000; we = 4'b0000; cs = 1'b0; push = 1'b0; pop = 1'b0; ce = 1'b0;
        @(posedge clk);
        #1;
        for (int v = 0; v < tbl.size(); v++) begin
            rst = tbl[v].rst; din = tbl[v].din; we = tbl[v].we; cs = tbl[v].cs;
            push = tbl[v].push; pop = tbl[v].pop; ce = tbl[v].ce;
            @(posedge clk);
            #1;
            chk_all(v, tbl[v].e_out, tbl[v].e_cnt, tbl[v].e_ovf, tbl[v].e_unf);
        end

        // Randomized phase against the reference model
        m_flags = 4'b0000;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        for (int n = 0; n < 600; n++) begin
            rst  = (n == 0) || ($urandom_range(0, 59) == 0);
            din  = 4'($urandom_range(0, 15));
            we   = 4'($urandom_range(0, 15));
            cs   = ($urandom_range(0, 5) == 0);
            push = ($urandom_range(0, 2) == 0);
            pop  = ($urandom_range(0, 2) == 0);
            ce   = ($urandom_range(0, 9) == 0);
            model_step();
            @(posedge clk);
            #1;
            chk_all(1000 + n, m_flags, 3'(m_stack.size()), m_ovf, m_unf);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
